// File: rtl/pe_sequencer.sv
// Window sequencer for a KSIZE x KSIZE processing element: walks the image
// row-major with stride 1 and, for each window, pulses the PE start, steps
// through the kernel taps, pulses the PE stop and waits for the result to be
// accepted downstream.
module pe_sequencer #(
    parameter int unsigned DIM_W = 8,
    parameter int unsigned KSIZE = 3
) (
    input  logic             PE_SEQUENCER_Clk,
    input  logic             PE_SEQUENCER_Reset,
    input  logic             PE_SEQUENCER_Start,
    input  logic             PE_SEQUENCER_Abort,
    input  logic [DIM_W-1:0] PE_SEQUENCER_Img_Width,
    input  logic [DIM_W-1:0] PE_SEQUENCER_Img_Height,
    input  logic             PE_SEQUENCER_Result_Ack,
    output logic             PE_SEQUENCER_Start_Routine,
    output logic             PE_SEQUENCER_Stop_Routine,
    output logic [7:0]       PE_SEQUENCER_Mac_Index,
    output logic [DIM_W-1:0] PE_SEQUENCER_Row,
    output logic [DIM_W-1:0] PE_SEQUENCER_Col,
    output logic             PE_SEQUENCER_Result_Valid,
    output logic             PE_SEQUENCER_Busy,
    output logic             PE_SEQUENCER_Done,
    output logic             PE_SEQUENCER_Error
);

    localparam int unsigned      MAC_W    = 8;
    localparam int unsigned      KK       = KSIZE * KSIZE;
    localparam logic [MAC_W-1:0] MAC_LAST = MAC_W'(KK - 1);
    localparam logic [DIM_W-1:0] K_DIM    = DIM_W'(KSIZE);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_START    = 3'd1;
    localparam logic [2:0] S_ACCUM    = 3'd2;
    localparam logic [2:0] S_STOP     = 3'd3;
    localparam logic [2:0] S_WAIT_ACK = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;
    localparam logic [2:0] S_ABORT    = 3'd6;

    logic [2:0]       state_q, state_d;
    logic [DIM_W-1:0] width_q, width_d;
    logic [DIM_W-1:0] height_q, height_d;
    logic [DIM_W-1:0] row_q, row_d;
    logic [DIM_W-1:0] col_q, col_d;
    logic [MAC_W-1:0] mac_q, mac_d;
    logic             error_d;

    logic start_routine_q;
    logic stop_routine_q;
    logic result_valid_q;
    logic busy_q;
    logic done_q;
    logic error_q;

    // Next-state, dimension latch, window position and tap counter.
    always_comb begin
        state_d  = state_q;
        width_d  = width_q;
        height_d = height_q;
        row_d    = row_q;
        col_d    = col_q;
        mac_d    = '0;
        error_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (PE_SEQUENCER_Start) begin
                    if ((PE_SEQUENCER_Img_Width >= K_DIM) &&
                        (PE_SEQUENCER_Img_Height >= K_DIM)) begin
                        width_d  = PE_SEQUENCER_Img_Width;
                        height_d = PE_SEQUENCER_Img_Height;
                        row_d    = '0;
                        col_d    = '0;
                        state_d  = S_START;
                    end else begin
                        error_d = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_START: state_d = S_ACCUM;
            S_ACCUM: begin
                if (mac_q == MAC_LAST) begin
                    state_d = S_STOP;
                end else begin
                    mac_d = mac_q + MAC_W'(1);
                end
            end
            S_STOP: state_d = S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (PE_SEQUENCER_Result_Ack) begin
                    if (col_q < (width_q - K_DIM)) begin
                        col_d   = col_q + DIM_W'(1);
                        state_d = S_START;
                    end else if (row_q < (height_q - K_DIM)) begin
                        col_d   = '0;
                        row_d   = row_q + DIM_W'(1);
                        state_d = S_START;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ABORT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort wins over every other transition, including a pending ack.
        if (PE_SEQUENCER_Abort && (state_q != S_IDLE) && (state_q != S_ABORT)) begin
            state_d = S_ABORT;
            mac_d   = '0;
            row_d   = row_q;
            col_d   = col_q;
            error_d = 1'b0;
        end
    end

    // State, counters and Moore outputs decoded from the next state.
    always_ff @(posedge PE_SEQUENCER_Clk) begin
        if (PE_SEQUENCER_Reset) begin
            state_q         <= S_IDLE;
            width_q         <= '0;
            height_q        <= '0;
            row_q           <= '0;
            col_q           <= '0;
            mac_q           <= '0;
            start_routine_q <= 1'b0;
            stop_routine_q  <= 1'b0;
            result_valid_q  <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            error_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            width_q         <= width_d;
            height_q        <= height_d;
            row_q           <= row_d;
            col_q           <= col_d;
            mac_q           <= mac_d;
            start_routine_q <= (state_d == S_START);
            stop_routine_q  <= (state_d == S_STOP) || (state_d == S_ABORT);
            result_valid_q  <= (state_d == S_WAIT_ACK);
            busy_q          <= (state_d != S_IDLE) && (state_d != S_DONE);
            done_q          <= (state_d == S_DONE);
            error_q         <= error_d;
        end
    end

    assign PE_SEQUENCER_Start_Routine = start_routine_q;
    assign PE_SEQUENCER_Stop_Routine  = stop_routine_q;
    assign PE_SEQUENCER_Mac_Index     = mac_q;
    assign PE_SEQUENCER_Row           = row_q;
    assign PE_SEQUENCER_Col           = col_q;
    assign PE_SEQUENCER_Result_Valid  = result_valid_q;
    assign PE_SEQUENCER_Busy          = busy_q;
    assign PE_SEQUENCER_Done          = done_q;
    assign PE_SEQUENCER_Error         = error_q;

endmodule

// File: tb/tb_pe_sequencer.sv
// Directed bench for pe_sequencer (KSIZE=3, DIM_W=8).
module tb_pe_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] width;
    logic [7:0] height;
    logic       ack;
    logic       sr;
    logic       stop;
    logic [7:0] mac;
    logic [7:0] row;
    logic [7:0] col;
    logic       valid;
    logic       busy;
    logic       done;
    logic       err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pe_sequencer #(.DIM_W(8), .KSIZE(3)) dut (
        .PE_SEQUENCER_Clk          (clk),
        .PE_SEQUENCER_Reset        (rst),
        .PE_SEQUENCER_Start        (start),
        .PE_SEQUENCER_Abort        (abort),
        .PE_SEQUENCER_Img_Width    (width),
        .PE_SEQUENCER_Img_Height   (height),
        .PE_SEQUENCER_Result_Ack   (ack),
        .PE_SEQUENCER_Start_Routine(sr),
        .PE_SEQUENCER_Stop_Routine (stop),
        .PE_SEQUENCER_Mac_Index    (mac),
        .PE_SEQUENCER_Row          (row),
        .PE_SEQUENCER_Col          (col),
        .PE_SEQUENCER_Result_Valid (valid),
        .PE_SEQUENCER_Busy         (busy),
        .PE_SEQUENCER_Done         (done),
        .PE_SEQUENCER_Error        (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_sr"},    32'(sr),    0);
        check({tag, "_stop"},  32'(stop),  0);
        check({tag, "_valid"}, 32'(valid), 0);
        check({tag, "_busy"},  32'(busy),  0);
        check({tag, "_done"},  32'(done),  0);
        check({tag, "_err"},   32'(err),   0);
        check({tag, "_mac"},   32'(mac),   0);
        check({tag, "_row"},   32'(row),   0);
        check({tag, "_col"},   32'(col),   0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        int nwin;
        int ndone;
        int nstop;
        int found;
        int overlap;
        int er[6];
        int ec[6];
        er = '{0, 0, 0, 1, 1, 1};
        ec = '{0, 1, 2, 0, 1, 2};

        // Reset overrides start and abort
        rst = 1'b1; start = 1'b1; abort = 1'b1; ack = 1'b0;
        width = 8'd3; height = 8'd3;
        tick(); tick();
        check_idle_outputs("reset");
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        tick();

        // Single 3x3 window, ack held high: exact cycle timeline
        width = 8'd3; height = 8'd3; ack = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            check($sformatf("t33_sr_c%0d", c),    32'(sr),    32'(c == 1));
            check($sformatf("t33_mac_c%0d", c),   32'(mac),   (c >= 2 && c <= 10) ? 32'(c - 2) : 0);
            check($sformatf("t33_stop_c%0d", c),  32'(stop),  32'(c == 11));
            check($sformatf("t33_valid_c%0d", c), 32'(valid), 32'(c == 12));
            check($sformatf("t33_done_c%0d", c),  32'(done),  32'(c == 13));
            check($sformatf("t33_busy_c%0d", c),  32'(busy),  32'(c >= 1 && c <= 12));
            check($sformatf("t33_err_c%0d", c),   32'(err),   0);
            tick();
        end

        // 5x4 image: six windows in row-major order, one done
        width = 8'd5; height = 8'd4; ack = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        nwin = 0; ndone = 0; overlap = 0;
        for (int c = 0; c < 120 && ndone == 0; c++) begin
            if (sr) begin
                if (nwin < 6) begin
                    check($sformatf("t34_row_w%0d", nwin), 32'(row), 32'(er[nwin]));
                    check($sformatf("t34_col_w%0d", nwin), 32'(col), 32'(ec[nwin]));
                end
                nwin++;
            end
            if (sr && stop) overlap = 1;
            if (done) begin
                ndone++;
                check("t34_done_err", 32'(err), 0);
            end
            tick();
        end
        check("t34_windows", 32'(nwin), 6);
        check("t34_done_cnt", 32'(ndone), 1);
        check("t34_sr_stop_overlap", 32'(overlap), 0);
        check("t34_busy_after", 32'(busy), 0);

        // Undersized image: error and done together, never busy
        width = 8'd2; height = 8'd8; start = 1'b1;
        tick();
        start = 1'b0;
        check("t35_sr", 32'(sr), 0);
        check("t35_done", 32'(done), 1);
        check("t35_err", 32'(err), 1);
        check("t35_busy", 32'(busy), 0);
        tick();
        check("t35_sr2", 32'(sr), 0);
        check("t35_done2", 32'(done), 0);
        check("t35_err2", 32'(err), 0);
        check("t35_busy2", 32'(busy), 0);

        // Abort at tap 4 of the first window
        width = 8'd3; height = 8'd3; ack = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        found = 0;
        for (int c = 0; c < 20; c++) begin
            if (mac == 8'd4) begin
                found = 1;
                break;
            end
            tick();
        end
        check("t36_reach_tap4", 32'(found), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t36_stop", 32'(stop), 1);
        check("t36_done", 32'(done), 0);
        check("t36_busy", 32'(busy), 1);
        check("t36_mac", 32'(mac), 0);
        tick();
        check("t36_stop_once", 32'(stop), 0);
        check("t36_done_after", 32'(done), 0);
        check("t36_idle_busy", 32'(busy), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t36_restart", 32'(sr), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();

        // Ack withheld 20 cycles with a stray start in between
        width = 8'd4; height = 8'd3; ack = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        found = 0;
        for (int c = 0; c < 30; c++) begin
            if (valid) begin
                found = 1;
                break;
            end
            tick();
        end
        check("t37_reach_wait", 32'(found), 1);
        for (int i = 0; i < 20; i++) begin
            check($sformatf("t37_hold_i%0d", i), {29'd0, valid, row[0], col[0]}, 32'd4);
            start = (i == 5);
            tick();
        end
        start = 1'b0;
        check("t37_sr_idle_wait", 32'(sr), 0);
        ack = 1'b1;
        tick();
        check("t37_resume_sr", 32'(sr), 1);
        check("t37_resume_col", 32'(col), 1);
        check("t37_resume_row", 32'(row), 0);
        found = 0;
        for (int c = 0; c < 30; c++) begin
            if (done) begin
                found = 1;
                break;
            end
            tick();
        end
        check("t37_done", 32'(found), 1);
        tick();
        nwin = 0;
        for (int c = 0; c < 4; c++) begin
            if (sr || busy) nwin++;
            tick();
        end
        check("t37_no_queued_start", 32'(nwin), 0);

        // Reset in the middle of the second window's accumulate
        width = 8'd4; height = 8'd3; ack = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        found = 0;
        for (int c = 0; c < 60; c++) begin
            if (col == 8'd1 && mac == 8'd2) begin
                found = 1;
                break;
            end
            tick();
        end
        check("t38_reach_accum", 32'(found), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_outputs("t38");
        nstop = 0;
        for (int c = 0; c < 15; c++) begin
            if (stop || sr || busy) nstop++;
            tick();
        end
        check("t38_quiet_after", 32'(nstop), 0);
        ack = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_sequencer.md
PE_SEQUENCER -- requirements
Module: pe_sequencer

Interface
REQ-001 Parameter DIM_W, default 8, SHALL set the width of the image dimension and window coordinate signals.
REQ-002 Parameter KSIZE, default 3, SHALL set the square kernel edge; legal range 1..15.
REQ-003 PE_SEQUENCER_Clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 PE_SEQUENCER_Reset  in  1  SHALL be the synchronous, active-high reset.
REQ-005 PE_SEQUENCER_Start  in  1  SHALL request a pass; sampled only in IDLE.
REQ-006 PE_SEQUENCER_Abort  in  1  SHALL terminate the current pass; sampled in every non-IDLE, non-ABORT state.
REQ-007 PE_SEQUENCER_Img_Width, PE_SEQUENCER_Img_Height  in  DIM_W each  SHALL give the image size; latched with Start.
REQ-008 PE_SEQUENCER_Result_Ack  in  1  SHALL signal downstream acceptance of the current window result.
REQ-009 PE_SEQUENCER_Start_Routine, PE_SEQUENCER_Stop_Routine  out  1 each  SHALL be the start and stop pulses driven to the PE dataflow controller.
REQ-010 PE_SEQUENCER_Mac_Index  out  8  SHALL give the kernel tap index within the current window.
REQ-011 PE_SEQUENCER_Row, PE_SEQUENCER_Col  out  DIM_W each  SHALL give the top-left coordinate of the current window.
REQ-012 PE_SEQUENCER_Result_Valid, PE_SEQUENCER_Busy, PE_SEQUENCER_Done, PE_SEQUENCER_Error  out  1 each  SHALL give result-ready, pass-active, pass-complete pulse and bad-config pulse.

Function
REQ-013 The FSM SHALL have states IDLE, START, ACCUM, STOP, WAIT_ACK, DONE, ABORT; all outputs SHALL be Moore, decoded from registered state and counters.
REQ-014 IDLE with Start=1 and Width>=KSIZE and Height>=KSIZE SHALL latch both dimensions, clear Row/Col, and go to START.
REQ-015 IDLE with Start=1 and Width<KSIZE or Height<KSIZE SHALL go to DONE, which asserts Error=1 together with Done=1 for that one cycle.
REQ-016 START SHALL last one cycle with Start_Routine=1, then go to ACCUM.
REQ-017 ACCUM SHALL last exactly KSIZE*KSIZE cycles, with Mac_Index = 0,1,...,KSIZE*KSIZE-1, then go to STOP; Mac_Index SHALL be 0 outside ACCUM.
REQ-018 STOP SHALL last one cycle with Stop_Routine=1, then go to WAIT_ACK.
REQ-019 WAIT_ACK SHALL hold Result_Valid=1 until Result_Ack=1; Row/Col SHALL stay stable meanwhile; Result_Ack outside WAIT_ACK SHALL be ignored.
REQ-020 On ack, if Col<Width-KSIZE: Col+1 and go to START.
REQ-021 On ack, else if Row<Height-KSIZE: Col=0, Row+1 and go to START.
REQ-022 On ack, else: go to DONE.
REQ-023 Window order SHALL be row-major with stride 1; a pass SHALL contain (W-KSIZE+1)*(H-KSIZE+1) windows.
REQ-024 DONE SHALL last one cycle with Done=1, then go to IDLE.
REQ-025 Busy SHALL be 1 in every state except IDLE and DONE.
REQ-026 Start_Routine and Stop_Routine SHALL never be 1 in the same cycle.
REQ-027 Minimum cycles per window SHALL be KSIZE*KSIZE+3 from the START cycle to the ack cycle inclusive.
REQ-028 Abort=1 in START, ACCUM, STOP, WAIT_ACK or DONE SHALL go to ABORT next cycle; Abort SHALL take priority over Result_Ack.
REQ-029 ABORT SHALL last one cycle with Stop_Routine=1, Done=0, then go to IDLE.
REQ-030 Start asserted while Busy=1 SHALL be ignored and SHALL NOT be queued.

Reset
REQ-031 Reset=1 SHALL force IDLE on the next edge from any state, including mid-pass, and override Start and Abort.
REQ-032 In and after reset: Start_Routine=0, Stop_Routine=0, Result_Valid=0, Busy=0, Done=0, Error=0, Mac_Index=0, Row=0, Col=0, and latched dimensions=0.

Verification
REQ-033 KSIZE=3, W=H=3, Start at cycle 0, Result_Ack held 1 -> Start_Routine at cycle 1; Mac_Index 0..8 over cycles 2-10; Stop_Routine at cycle 11; Result_Valid at cycle 12; Done at cycle 13; IDLE at cycle 14.
REQ-034 KSIZE=3, W=5, H=4, Result_Ack held 1 -> exactly 6 Start_Routine pulses with (Row,Col) = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2), then one Done.
REQ-035 W=2, H=8, Start -> no Start_Routine; Done=1 and Error=1 in the same single cycle; Busy stays 0.
REQ-036 Abort at Mac_Index=4 of the first window -> ABORT next cycle with a single Stop_Routine pulse, no Done, IDLE after, and a new Start is accepted.
REQ-037 Result_Ack withheld for 20 cycles in WAIT_ACK, with a Start pulse applied meanwhile -> Result_Valid held, Row/Col stable, the Start has no effect, and the pass resumes on ack.
REQ-038 Reset pulsed during ACCUM -> all outputs match REQ-032 on the next cycle, and no Stop_Routine pulse is emitted.
